// File: rtl/pe_cluster_port.sv
// PE-side port of a cluster crossbar: TX FIFO feeding a held head register,
// RX FIFO with drop accounting and address checking.
module pe_cluster_port #(
  parameter int D_W      = 32,
  parameter int X_W      = 2,
  parameter int Y_W      = 2,
  parameter int C_W      = 4,
  parameter int X        = 0,
  parameter int Y        = 0,
  parameter int PE_ID    = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  localparam int P_W     = 1 + X_W + Y_W + C_W + D_W,
  localparam int TA_W    = $clog2(TX_DEPTH),
  localparam int RA_W    = $clog2(RX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [X_W-1:0]   tx_dst_x,
  input  logic [Y_W-1:0]   tx_dst_y,
  input  logic [C_W-1:0]   tx_dst_pe,
  input  logic [D_W-1:0]   tx_data,
  output logic [P_W-1:0]   peout_packet,
  input  logic             ack,
  input  logic [P_W-1:0]   pein_packet,
  input  logic             pein_vld,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [D_W-1:0]   rx_data,
  output logic [TA_W:0]    tx_count,
  output logic             rx_overflow,
  output logic             rx_misroute,
  output logic [7:0]       drop_count,
  output logic             idle
);

  localparam logic [X_W-1:0] OWN_X  = X_W'(X);
  localparam logic [Y_W-1:0] OWN_Y  = Y_W'(Y);
  localparam logic [C_W-1:0] OWN_PE = C_W'(PE_ID);

  logic [P_W-1:0]  tx_mem [TX_DEPTH];
  logic [TA_W-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
  logic [TA_W:0]   tx_count_r, tx_count_next_s;
  logic [P_W-1:0]  head_r, head_next_s;

  logic [D_W-1:0]  rx_mem [RX_DEPTH];
  logic [RA_W-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
  logic [RA_W:0]   rx_count_r, rx_count_next_s;
  logic            rx_overflow_r, rx_misroute_r;
  logic [7:0]      drop_count_r;

  logic            tx_push_s, head_take_s, tx_nonempty_s, tx_pop_s, tx_wr_s;
  logic [P_W-1:0]  push_pkt_s;
  logic            rx_req_s, rx_pop_s, rx_full_s, rx_wr_s, rx_drop_s, rx_bad_addr_s;

  assign tx_ready      = (tx_count_r < (TA_W+1)'(TX_DEPTH));
  assign tx_push_s     = ce & tx_valid & tx_ready;
  assign push_pkt_s    = {1'b1, tx_dst_x, tx_dst_y, tx_dst_pe, tx_data};
  assign head_take_s   = ce & (~head_r[P_W-1] | ack);
  assign tx_nonempty_s = (tx_count_r != (TA_W+1)'(0));
  assign tx_pop_s      = head_take_s & tx_nonempty_s;
  // A push into a free head with an empty FIFO bypasses the FIFO entirely.
  assign tx_wr_s       = tx_push_s & ~(head_take_s & ~tx_nonempty_s);

  assign rx_valid      = (rx_count_r != (RA_W+1)'(0));
  assign rx_req_s      = ce & pein_vld;
  assign rx_pop_s      = ce & rx_valid & rx_ready;
  assign rx_full_s     = (rx_count_r == (RA_W+1)'(RX_DEPTH));
  assign rx_wr_s       = rx_req_s & (~rx_full_s | rx_pop_s);
  assign rx_drop_s     = rx_req_s & rx_full_s & ~rx_pop_s;
  assign rx_bad_addr_s = ~pein_packet[P_W-1] |
                         (pein_packet[P_W-2 -: X_W+Y_W+C_W] != {OWN_X, OWN_Y, OWN_PE});

  assign peout_packet  = head_r;
  assign tx_count      = tx_count_r;
  assign rx_data       = rx_valid ? rx_mem[rx_rd_ptr_r] : D_W'(0);
  assign rx_overflow   = rx_overflow_r;
  assign rx_misroute   = rx_misroute_r;
  assign drop_count    = drop_count_r;
  assign idle          = ~head_r[P_W-1] & ~tx_nonempty_s & ~rx_valid;

  // Next head value and TX occupancy.
  always_comb begin
    head_next_s     = head_r;
    tx_count_next_s = tx_count_r;
    if (head_take_s) begin
      if (tx_nonempty_s) begin
        head_next_s = tx_mem[tx_rd_ptr_r];
      end else if (tx_push_s) begin
        head_next_s = push_pkt_s;
      end else begin
        head_next_s = P_W'(0);
      end
    end else begin
      head_next_s = head_r;
    end
    case ({tx_wr_s, tx_pop_s})
      2'b10:   tx_count_next_s = tx_count_r + (TA_W+1)'(1);
      2'b01:   tx_count_next_s = tx_count_r - (TA_W+1)'(1);
      default: tx_count_next_s = tx_count_r;
    endcase
  end

  // Next RX occupancy.
  always_comb begin
    rx_count_next_s = rx_count_r;
    case ({rx_wr_s, rx_pop_s})
      2'b10:   rx_count_next_s = rx_count_r + (RA_W+1)'(1);
      2'b01:   rx_count_next_s = rx_count_r - (RA_W+1)'(1);
      default: rx_count_next_s = rx_count_r;
    endcase
  end

  // FIFO storage; contents are qualified by the counters so need no reset.
  always_ff @(posedge clk) begin
    if (tx_wr_s) tx_mem[tx_wr_ptr_r] <= push_pkt_s;
    if (rx_wr_s) rx_mem[rx_wr_ptr_r] <= pein_packet[D_W-1:0];
  end

  // TX head, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r      <= P_W'(0);
      tx_wr_ptr_r <= TA_W'(0);
      tx_rd_ptr_r <= TA_W'(0);
      tx_count_r  <= (TA_W+1)'(0);
    end else begin
      head_r     <= head_next_s;
      tx_count_r <= tx_count_next_s;
      if (tx_wr_s)  tx_wr_ptr_r <= tx_wr_ptr_r + TA_W'(1);
      if (tx_pop_s) tx_rd_ptr_r <= tx_rd_ptr_r + TA_W'(1);
    end
  end

  // RX pointers, occupancy and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_r   <= RA_W'(0);
      rx_rd_ptr_r   <= RA_W'(0);
      rx_count_r    <= (RA_W+1)'(0);
      rx_overflow_r <= 1'b0;
      rx_misroute_r <= 1'b0;
      drop_count_r  <= 8'd0;
    end else begin
      rx_count_r <= rx_count_next_s;
      if (rx_wr_s)  rx_wr_ptr_r <= rx_wr_ptr_r + RA_W'(1);
      if (rx_pop_s) rx_rd_ptr_r <= rx_rd_ptr_r + RA_W'(1);
      if (rx_drop_s) begin
        rx_overflow_r <= 1'b1;
        if (drop_count_r != 8'hFF) drop_count_r <= drop_count_r + 8'd1;
      end
      if (rx_req_s && rx_bad_addr_s) rx_misroute_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_cluster_port.sv
// Directed self-checking bench for pe_cluster_port with default parameters.
module tb_pe_cluster_port;
  logic        clk = 1'b0;
  logic        rst, ce, tx_valid, tx_ready, ack, pein_vld, rx_valid, rx_ready;
  logic [1:0]  tx_dst_x, tx_dst_y;
  logic [3:0]  tx_dst_pe;
  logic [31:0] tx_data, rx_data;
  logic [40:0] peout_packet, pein_packet;
  logic [2:0]  tx_count;
  logic        rx_overflow, rx_misroute, idle;
  logic [7:0]  drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  pe_cluster_port dut (
    .clk(clk), .rst(rst), .ce(ce),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y), .tx_dst_pe(tx_dst_pe), .tx_data(tx_data),
    .peout_packet(peout_packet), .ack(ack),
    .pein_packet(pein_packet), .pein_vld(pein_vld),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_count(tx_count), .rx_overflow(rx_overflow), .rx_misroute(rx_misroute),
    .drop_count(drop_count), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [40:0] mk(input logic [1:0] x, input logic [1:0] y,
                                     input logic [3:0] c, input logic [31:0] d);
    return {1'b1, x, y, c, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_peout"}, 64'(peout_packet), 64'd0);
    chk({tag, "_txcnt"}, 64'(tx_count), 64'd0);
    chk({tag, "_rxvalid"}, 64'(rx_valid), 64'd0);
    chk({tag, "_rxdata"}, 64'(rx_data), 64'd0);
    chk({tag, "_ovf"}, 64'(rx_overflow), 64'd0);
    chk({tag, "_misr"}, 64'(rx_misroute), 64'd0);
    chk({tag, "_drops"}, 64'(drop_count), 64'd0);
    chk({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  task automatic rx_beat(input logic [40:0] pkt);
    pein_packet = pkt;
    pein_vld    = 1'b1;
    tick();
    pein_vld    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; tx_valid = 1'b0; ack = 1'b0; pein_vld = 1'b0; rx_ready = 1'b0;
    tx_dst_x = 2'd0; tx_dst_y = 2'd0; tx_dst_pe = 4'd0; tx_data = 32'd0; pein_packet = 41'd0;
    tick(); tick();
    reset_checks("rst");
    rst = 1'b0;
    #1;
    chk("rst_txready", 64'(tx_ready), 64'd1);

    // Single packet, held until ack.
    tx_dst_x = 2'd1; tx_dst_y = 2'd2; tx_dst_pe = 4'd5; tx_data = 32'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("single_c1", 64'(peout_packet), 64'(mk(2'd1, 2'd2, 4'd5, 32'hA5)));
    chk("single_cnt", 64'(tx_count), 64'd0);
    chk("single_busy", 64'(idle), 64'd0);
    tick();
    chk("single_c2", 64'(peout_packet), 64'(mk(2'd1, 2'd2, 4'd5, 32'hA5)));
    tick();
    chk("single_c3", 64'(peout_packet), 64'(mk(2'd1, 2'd2, 4'd5, 32'hA5)));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("single_gone", 64'(peout_packet), 64'd0);
    chk("single_idle", 64'(idle), 64'd1);

    // Burst of 5 fills head plus the 4-entry FIFO, then drains with no bubble.
    tx_dst_x = 2'd3; tx_dst_y = 2'd1; tx_dst_pe = 4'd9;
    for (int i = 0; i < 5; i++) begin
      tx_data = 32'h10 + 32'(i); tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    chk("burst_cnt", 64'(tx_count), 64'd4);
    chk("burst_rdy", 64'(tx_ready), 64'd0);
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain_pkt%0d", i), 64'(peout_packet), 64'(mk(2'd3, 2'd1, 4'd9, 32'h10 + 32'(i))));
      chk($sformatf("drain_cnt%0d", i), 64'(tx_count), 64'(4 - i));
      tick();
    end
    ack = 1'b0;
    chk("drain_empty", 64'(peout_packet), 64'd0);
    chk("drain_idle", 64'(idle), 64'd1);

    // Head refill from FIFO while pushing leaves tx_count unchanged.
    tx_dst_x = 2'd0; tx_dst_y = 2'd0; tx_dst_pe = 4'd2;
    tx_data = 32'h50; tx_valid = 1'b1; tick();
    tx_data = 32'h51; tick();
    chk("refill_pre", 64'(tx_count), 64'd1);
    tx_data = 32'h52; ack = 1'b1; tick();
    tx_valid = 1'b0;
    chk("refill_cnt", 64'(tx_count), 64'd1);
    chk("refill_head", 64'(peout_packet), 64'(mk(2'd0, 2'd0, 4'd2, 32'h51)));
    tick();
    chk("refill_head2", 64'(peout_packet), 64'(mk(2'd0, 2'd0, 4'd2, 32'h52)));
    tick();
    ack = 1'b0;
    chk("refill_done", 64'(idle), 64'd1);

    // RX overflow: 6 beats into 4 entries.
    for (int i = 1; i <= 6; i++) rx_beat(mk(2'd0, 2'd0, 4'd0, 32'(i)));
    chk("ovf_flag", 64'(rx_overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd2);
    chk("ovf_misr", 64'(rx_misroute), 64'd0);
    rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_rd%0d", i), 64'(rx_data), 64'(i));
      tick();
    end
    rx_ready = 1'b0;
    chk("ovf_empty", 64'(rx_valid), 64'd0);

    // Full RX FIFO with simultaneous push and pop: nothing dropped.
    for (int i = 1; i <= 4; i++) rx_beat(mk(2'd0, 2'd0, 4'd0, 32'h20 + 32'(i)));
    pein_packet = mk(2'd0, 2'd0, 4'd0, 32'h25); pein_vld = 1'b1; rx_ready = 1'b1;
    tick();
    pein_vld = 1'b0;
    chk("full_nodrop", 64'(drop_count), 64'd2);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("full_rd%0d", i), 64'(rx_data), 64'(32'h20 + 32'(i)));
      tick();
    end
    rx_ready = 1'b0;
    chk("full_empty", 64'(rx_valid), 64'd0);

    // Misrouted packet is delivered and flagged; ack with empty head is ignored.
    rx_beat(mk(2'd0, 2'd0, 4'd1, 32'h77));
    chk("misr_flag", 64'(rx_misroute), 64'd1);
    chk("misr_data", 64'(rx_data), 64'h77);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("noack_peout", 64'(peout_packet), 64'd0);
    chk("noack_cnt", 64'(tx_count), 64'd0);
    chk("noack_rx", 64'(rx_data), 64'h77);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    chk("misr_idle", 64'(idle), 64'd1);

    // Clock enable low freezes everything.
    tx_dst_x = 2'd2; tx_dst_y = 2'd3; tx_dst_pe = 4'd7; tx_data = 32'h31; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    rx_beat(mk(2'd0, 2'd0, 4'd0, 32'h41));
    ce = 1'b0; ack = 1'b1; pein_vld = 1'b1; rx_ready = 1'b1; tx_valid = 1'b1;
    pein_packet = mk(2'd0, 2'd0, 4'd0, 32'h42); tx_data = 32'h33;
    tick(); tick();
    chk("ce_peout", 64'(peout_packet), 64'(mk(2'd2, 2'd3, 4'd7, 32'h31)));
    chk("ce_txcnt", 64'(tx_count), 64'd0);
    chk("ce_rxdata", 64'(rx_data), 64'h41);
    chk("ce_drops", 64'(drop_count), 64'd2);
    ack = 1'b0; pein_vld = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; ce = 1'b1;

    // Reset mid-burst discards everything.
    tx_valid = 1'b1; pein_vld = 1'b1;
    tick(); tick();
    chk("pre_rst_cnt", 64'(tx_count), 64'd2);
    rst = 1'b1;
    #1;
    reset_checks("mid_rst");
    tick();
    tx_valid = 1'b0; pein_vld = 1'b0;
    rst = 1'b0;
    tick();
    reset_checks("post_rst");
    chk("post_rst_rdy", 64'(tx_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
